// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, conditional relative branch, jump,
// call/return through a small LIFO of return addresses, with stall hold.
module pc_sequencer #(
    parameter int                    ADDR_WIDTH   = 11,
    parameter int                    OFFSET_WIDTH = 8,
    parameter int                    STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             stall,
    input  logic [2:0]                       op,
    input  logic                             cond,
    input  logic [OFFSET_WIDTH-1:0]          offset,
    input  logic [ADDR_WIDTH-1:0]            target,
    output logic [ADDR_WIDTH-1:0]            pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_depth,
    output logic                             overflow,
    output logic                             underflow
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RETURN = 3'b100;

    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] offset_ext;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic [DW-1:0]         depth_next;
    logic                  overflow_next;
    logic                  underflow_next;
    logic                  push;
    logic                  stack_full;
    logic                  stack_empty;
    logic [IW-1:0]         push_idx;
    logic [IW-1:0]         top_idx;

    assign pc_inc      = pc + ADDR_WIDTH'(1);
    assign offset_ext  = ADDR_WIDTH'($signed(offset));
    assign stack_full  = (stack_depth == DW'(STACK_DEPTH));
    assign stack_empty = (stack_depth == '0);
    // Depth doubles as the next free slot; the top entry sits one below it.
    assign push_idx    = IW'(stack_depth);
    assign top_idx     = IW'(stack_depth - DW'(1));

    always_comb begin
        pc_next        = pc_inc;
        depth_next     = stack_depth;
        overflow_next  = overflow;
        underflow_next = underflow;
        push           = 1'b0;
        case (op)
            OP_BRANCH: begin
                if (cond) pc_next = pc + offset_ext;
            end
            OP_JUMP: pc_next = target;
            OP_CALL: begin
                if (!stack_full) begin
                    push       = 1'b1;
                    pc_next    = target;
                    depth_next = stack_depth + DW'(1);
                end else begin
                    overflow_next = 1'b1;
                end
            end
            OP_RETURN: begin
                if (!stack_empty) begin
                    pc_next    = stack_mem[top_idx];
                    depth_next = stack_depth - DW'(1);
                end else begin
                    underflow_next = 1'b1;
                end
            end
            default: pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_VECTOR;
            stack_depth <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else if (!stall) begin
            pc          <= pc_next;
            stack_depth <= depth_next;
            overflow    <= overflow_next;
            underflow   <= underflow_next;
        end
    end

    // Stack contents need no reset; only entries below the depth are ever read.
    always_ff @(posedge clock) begin
        if (!reset && !stall && push) stack_mem[push_idx] <= pc_inc;
    end

endmodule
